// File: rtl/axil_cmd_master_if.sv
// ============================================================================
// Module   : axil_cmd_master_if
// Brief    : AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axil_cmd_master_if #(
    parameter int ADDR_W = 4
) ();
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic              WVALID;
    logic              WREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              RVALID;
    logic              RREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

`default_nettype wire

// File: rtl/axil_cmd_master.sv
// ============================================================================
// Module   : axil_cmd_master
// Brief    : Single-outstanding AXI4-Lite master driven by a valid/ready
//            command port, with response port and timeout/drain watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axil_cmd_master #(
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire              ACLK,
    input  wire              ARESETn,
    input  wire              cmd_valid_i,
    output logic             cmd_ready_o,
    input  wire              cmd_write_i,
    input  wire [ADDR_W-1:0] cmd_addr_i,
    input  wire [31:0]       cmd_wdata_i,
    input  wire [3:0]        cmd_wstrb_i,
    output logic             rsp_valid_o,
    input  wire              rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic [1:0]       rsp_resp_o,
    output logic             rsp_timeout_o,
    axil_cmd_master_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam int                 c_CNT_W   = (TIMEOUT_CYCLES < 2) ? 2 : $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam bit                 c_WD_EN   = (TIMEOUT_CYCLES != 0);

    state_t              state_q;
    logic                cmd_ready_q;
    logic                write_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0]   awaddr_q, araddr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic                aw_done_q, w_done_q, b_done_q, ar_done_q, r_done_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic                rsp_valid_q, rsp_timeout_q;
    logic [31:0]         rsp_rdata_q;
    logic [1:0]          rsp_resp_q;

    logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                aw_done_d, w_done_d, b_done_d, ar_done_d, r_done_d;
    logic                w_quiet, w_expire;
    logic [c_CNT_W-1:0]  cnt_d;

    assign w_aw_hs = awvalid_q & axi.AWREADY;
    assign w_w_hs  = wvalid_q  & axi.WREADY;
    assign w_b_hs  = bready_q  & axi.BVALID;
    assign w_ar_hs = arvalid_q & axi.ARREADY;
    assign w_r_hs  = rready_q  & axi.RVALID;

    // Next-state flags fold in this cycle's handshakes so same-cycle B/R completes.
    assign aw_done_d = aw_done_q | w_aw_hs;
    assign w_done_d  = w_done_q  | w_w_hs;
    assign b_done_d  = b_done_q  | w_b_hs;
    assign ar_done_d = ar_done_q | w_ar_hs;
    assign r_done_d  = r_done_q  | w_r_hs;

    assign w_quiet  = write_q ? (aw_done_d & w_done_d & b_done_d) : (ar_done_d & r_done_d);
    assign cnt_d    = cnt_q + 1'b1;
    assign w_expire = c_WD_EN && (cnt_d == c_TIMEOUT);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            write_q       <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            b_done_q      <= 1'b0;
            ar_done_q     <= 1'b0;
            r_done_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            b_done_q  <= b_done_d;
            ar_done_q <= ar_done_d;
            r_done_q  <= r_done_d;
            awvalid_q <= awvalid_q & ~w_aw_hs;
            wvalid_q  <= wvalid_q  & ~w_w_hs;
            arvalid_q <= arvalid_q & ~w_ar_hs;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_ready_q   <= 1'b0;
                        write_q       <= cmd_write_i;
                        cnt_q         <= '0;
                        aw_done_q     <= 1'b0;
                        w_done_q      <= 1'b0;
                        b_done_q      <= 1'b0;
                        ar_done_q     <= 1'b0;
                        r_done_q      <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= '0;
                        rsp_timeout_q <= 1'b0;
                        if (cmd_write_i) begin
                            awaddr_q  <= cmd_addr_i;
                            wdata_q   <= cmd_wdata_i;
                            wstrb_q   <= cmd_wstrb_i;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            bready_q  <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            araddr_q  <= cmd_addr_i;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                            state_q   <= S_READ;
                        end
                    end
                end

                S_WRITE, S_READ: begin
                    cnt_q <= cnt_d;
                    if (w_b_hs) rsp_resp_q <= axi.BRESP;
                    if (w_r_hs) begin
                        rsp_rdata_q <= axi.RDATA;
                        rsp_resp_q  <= axi.RRESP;
                    end
                    // Completion takes priority over a coincident watchdog expiry.
                    if (w_quiet) begin
                        rsp_valid_q <= 1'b1;
                        bready_q    <= 1'b0;
                        rready_q    <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (w_expire) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= 2'b11;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_DRAIN;
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (rsp_valid_q && rsp_ready_i) rsp_valid_q <= 1'b0;
                    // Leave only when the bus is idle and the timeout response is gone.
                    if (w_quiet && (!rsp_valid_q || rsp_ready_i)) begin
                        bready_q    <= 1'b0;
                        rready_q    <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_timeout_o = rsp_timeout_q;

    assign axi.AWVALID = awvalid_q;
    assign axi.AWADDR  = awaddr_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.RREADY  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
// ============================================================================
// Module   : tb_axil_cmd_master
// Brief    : Scoreboard bench for axil_cmd_master with a delay-configurable
//            AXI4-Lite slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axil_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0, cmd_wstrb = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        cmd_ready_o, rsp_valid_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;

    axil_cmd_master_if #(.ADDR_W(4)) bus ();

    axil_cmd_master #(.ADDR_W(4), .TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o),
        .axi(bus)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave model: each READY rises after its VALID has waited <delay> cycles.
    logic [7:0]  aw_delay = '0, w_delay = '0, ar_delay = '0;
    logic [7:0]  aw_wait, w_wait, ar_wait;
    logic        aw_got, w_got, rvalid_q;
    logic [3:0]  raddr_q;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] mem [16];
    logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;

    assign bus.AWREADY = bus.AWVALID && (aw_wait >= aw_delay);
    assign bus.WREADY  = bus.WVALID  && (w_wait  >= w_delay);
    assign bus.ARREADY = bus.ARVALID && (ar_wait >= ar_delay);
    assign s_aw_hs = bus.AWVALID && bus.AWREADY;
    assign s_w_hs  = bus.WVALID  && bus.WREADY;
    assign s_ar_hs = bus.ARVALID && bus.ARREADY;
    assign bus.BVALID = (aw_got || s_aw_hs) && (w_got || s_w_hs);
    assign bus.BRESP  = bresp_cfg;
    assign s_b_hs  = bus.BVALID && bus.BREADY;
    assign bus.RVALID = rvalid_q;
    assign bus.RDATA  = rvalid_q ? mem[raddr_q] : 32'h0;
    assign bus.RRESP  = rresp_cfg;
    assign s_r_hs  = bus.RVALID && bus.RREADY;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_wait <= '0; w_wait <= '0; ar_wait <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; rvalid_q <= 1'b0; raddr_q <= '0;
        end else begin
            aw_wait <= (bus.AWVALID && !s_aw_hs) ? aw_wait + 8'd1 : 8'd0;
            w_wait  <= (bus.WVALID  && !s_w_hs)  ? w_wait  + 8'd1 : 8'd0;
            ar_wait <= (bus.ARVALID && !s_ar_hs) ? ar_wait + 8'd1 : 8'd0;
            if (s_b_hs) begin
                aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (s_aw_hs) aw_got <= 1'b1;
                if (s_w_hs)  w_got  <= 1'b1;
            end
            if (s_r_hs) rvalid_q <= 1'b0;
            if (s_ar_hs) begin rvalid_q <= 1'b1; raddr_q <= bus.ARADDR; end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every presented response and checks hold.
    exp_t cur;
    bit   in_rsp = 1'b0;
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            in_rsp = 1'b0;
        end else if (rsp_valid_o) begin
            if (!in_rsp) begin
                chk("rsp_expected_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    cur = exp_q[0];
                    chk("rsp_cycle", 64'(cyc), 64'(cur.due));
                end
            end
            chk("rsp_rdata",   rsp_rdata_o,   cur.rdata);
            chk("rsp_resp",    rsp_resp_o,    cur.resp);
            chk("rsp_timeout", rsp_timeout_o, cur.to);
            chk("cmd_ready_during_rsp", cmd_ready_o, 1'b0);
            if (rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                in_rsp = 1'b0;
            end else begin
                in_rsp = 1'b1;
            end
        end else begin
            in_rsp = 1'b0;
        end
    end

    // Entered and left at posedge+1; pushes the expected response on accept.
    task automatic send(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] e_rd, input logic [1:0] e_resp,
                        input logic e_to, input int lat, output int acc);
        bit   got = 1'b0;
        exp_t e;
        acc = -1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge ACLK);
            if (cmd_ready_o) begin
                got = 1'b1;
                acc = cyc;
                if (lat >= 0) begin
                    e.rdata = e_rd; e.resp = e_resp; e.to = e_to; e.due = acc + lat;
                    exp_q.push_back(e);
                end
            end
            @(posedge ACLK); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 64'(got), 64'd1);
    endtask

    int aw_cnt, w_cnt, aw_last, w_last, ar_last, cr_first;
    task automatic observe(input int n);
        aw_cnt = 0; w_cnt = 0; aw_last = -1; w_last = -1; ar_last = -1; cr_first = -1;
        for (int t = 0; t < n; t++) begin
            @(negedge ACLK);
            if (bus.AWVALID) begin aw_cnt++; aw_last = cyc; end
            if (bus.WVALID)  begin w_cnt++;  w_last  = cyc; end
            if (bus.ARVALID) ar_last = cyc;
            if (cmd_ready_o && cr_first < 0) cr_first = cyc;
            @(posedge ACLK); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    int acc, acc2, rv;
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEAD_BEEF;
        mem[8]  = 32'h1234_5678;
        mem[12] = 32'hA5A5_0F0F;

        @(negedge ACLK);
        chk("reset_cmd_ready", cmd_ready_o, 1'b1);
        chk("reset_valids", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
                             rsp_valid_o, rsp_timeout_o}, 7'd0);
        chk("reset_bus_data", {bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB}, 44'd0);
        chk("reset_rsp_data", {rsp_rdata_o, rsp_resp_o}, 34'd0);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // Write, always-ready slave, same-cycle B.
        send(1'b1, 4'h0, 32'h0000_0003, 4'hF, 32'h0, 2'b00, 1'b0, 2, acc);
        observe(4);
        chk("t1_awvalid_cycles", 64'(aw_cnt), 64'd1);
        chk("t1_wvalid_cycles",  64'(w_cnt),  64'd1);

        // Read with R one cycle after AR.
        send(1'b0, 4'h8, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0, 3, acc);
        observe(4);

        // AWREADY delayed 3, WREADY delayed 1, SLVERR on B.
        aw_delay = 8'd3; w_delay = 8'd1; bresp_cfg = 2'b10;
        send(1'b1, 4'h4, 32'hCAFE_F00D, 4'h3, 32'h0, 2'b10, 1'b0, 5, acc);
        observe(7);
        chk("t3_wvalid_last",   64'(w_last),  64'(acc + 2));
        chk("t3_wvalid_cycles", 64'(w_cnt),   64'd2);
        chk("t3_awvalid_last",  64'(aw_last), 64'(acc + 4));
        chk("t3_awvalid_cycles",64'(aw_cnt),  64'd4);
        aw_delay = 8'd0; w_delay = 8'd0; bresp_cfg = 2'b00;

        // Completion coincides with the watchdog limit: normal response wins.
        aw_delay = 8'd7;
        send(1'b1, 4'h1, 32'h0000_0011, 4'h1, 32'h0, 2'b00, 1'b0, 9, acc);
        observe(11);
        aw_delay = 8'd0;

        // Back-pressure: rsp_ready low while response is held.
        rsp_ready = 1'b0; rresp_cfg = 2'b10;
        send(1'b0, 4'hC, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b10, 1'b0, 3, acc);
        rv = -1;
        for (int t = 0; t < 20 && rv < 0; t++) begin
            @(negedge ACLK);
            if (rsp_valid_o) rv = cyc;
            else begin @(posedge ACLK); #1; end
        end
        chk("t4_rsp_seen", 64'(rv >= 0), 64'd1);
        repeat (5) @(posedge ACLK);
        #1 rsp_ready = 1'b1; rresp_cfg = 2'b00;
        send(1'b1, 4'h2, 32'h0000_00F0, 4'b0010, 32'h0, 2'b00, 1'b0, 2, acc2);
        chk("t4_next_accept", 64'(acc2), 64'(rv + 6));
        observe(4);

        // Timeout: ARREADY held off until cycle 20.
        ar_delay = 8'd19;
        send(1'b0, 4'h4, 32'h0, 4'h0, 32'h0, 2'b11, 1'b1, 9, acc);
        observe(30);
        chk("t5_arvalid_last",   64'(ar_last),  64'(acc + 20));
        chk("t5_cmd_ready_back", 64'(cr_first), 64'(acc + 22));
        chk("t5_late_rdata_dropped", rsp_rdata_o, 32'h0);
        ar_delay = 8'd0;

        // Asynchronous reset while AWVALID is pending.
        aw_delay = 8'd10;
        send(1'b1, 4'h6, 32'h0000_0066, 4'hF, 32'h0, 2'b00, 1'b0, -1, acc);
        @(negedge ACLK);
        chk("t6_awvalid_before_reset", bus.AWVALID, 1'b1);
        #2 ARESETn = 1'b0;
        #1 chk("t6_valids_async_clear", {bus.AWVALID, bus.WVALID, bus.BREADY}, 3'b000);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        ARESETn = 1'b1; aw_delay = 8'd0;
        @(negedge ACLK);
        chk("t6_cmd_ready_after_reset", cmd_ready_o, 1'b1);
        chk("t6_no_rsp_after_reset",   rsp_valid_o, 1'b0);
        @(posedge ACLK); #1;
        send(1'b1, 4'h5, 32'h0000_0055, 4'hF, 32'h0, 2'b00, 1'b0, 2, acc);
        observe(4);

        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge ACLK);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
